// File: rtl/core_clk_pkg.sv
// Shared types and helpers for the core clock sequencer and its transfer-window arbiter.
package core_clk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GRANT = 2'd2,
        ARB   = 2'd3
    } seq_state_t;

    localparam int unsigned MIN_HALF = 1;

    // Channel-index width; a single channel still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after pointer.
module rr_arbiter
    import core_clk_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]                req,
    input  logic [idx_width(NUM_CH)-1:0]     pointer,
    output logic [NUM_CH-1:0]                grant
);

    localparam int unsigned IW = idx_width(NUM_CH);

    logic          found;
    logic [IW-1:0] idx;

    // Scan wraps modulo NUM_CH so a pointer at the last channel continues from channel 0.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            idx = IW'((32'(pointer) + off) % NUM_CH);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_clock_sequencer.sv
// Divided core clock generator that freezes the clock low to open round-robin,
// watchdog-guarded transfer windows for up to NUM_CH requesters.
module core_clock_sequencer
    import core_clk_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DEFAULT_HALF = 2,
    parameter int unsigned MAX_GRANT    = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    input  logic [CNT_WIDTH-1:0]             half_period,
    input  logic [NUM_CH-1:0]                ch_req,
    input  logic [NUM_CH-1:0]                ch_done,
    input  logic                             err_clr,
    output logic                             core_clk,
    output logic                             core_rise,
    output logic                             core_fall,
    output logic [NUM_CH-1:0]                ch_grant,
    output logic                             stalled,
    output logic                             err_timeout,
    output logic [idx_width(NUM_CH)-1:0]     err_ch,
    output logic [31:0]                      rise_count
);

    localparam int unsigned              IW         = idx_width(NUM_CH);
    localparam int unsigned              WW         = $clog2(MAX_GRANT);
    localparam logic [WW-1:0]            WD_LAST    = WW'(MAX_GRANT - 1);
    localparam logic [CNT_WIDTH-1:0]     HALF_RESET = CNT_WIDTH'(DEFAULT_HALF);
    localparam logic [CNT_WIDTH-1:0]     HALF_MIN   = CNT_WIDTH'(MIN_HALF);

    seq_state_t           state;
    logic [CNT_WIDTH-1:0] phase_cnt;
    logic [CNT_WIDTH-1:0] half_active;
    logic [CNT_WIDTH-1:0] half_req;
    logic [WW-1:0]        wdog;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        next_ptr;
    logic [NUM_CH-1:0]    arb_grant;
    logic                 any_req;
    logic                 phase_end;
    logic                 done_hit;
    logic                 take_grant;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req     (ch_req),
        .pointer (rr_ptr),
        .grant   (arb_grant)
    );

    assign half_req  = (half_period < HALF_MIN) ? HALF_MIN : half_period;
    assign any_req   = |ch_req;
    assign phase_end = (phase_cnt == half_active - HALF_MIN);
    assign done_hit  = |(ch_done & ch_grant);
    assign stalled   = (state == GRANT) || (state == ARB);

    // A window opens from IDLE, from ARB, or on the edge that drives core_clk low.
    assign take_grant = any_req &&
                        ((state == IDLE) || (state == ARB) ||
                         ((state == RUN) && phase_end && core_clk));

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (arb_grant[i]) win_idx = IW'(i);
        end
        next_ptr = (win_idx == IW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            half_active <= HALF_RESET;
            wdog        <= '0;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            core_clk    <= 1'b0;
            core_rise   <= 1'b0;
            core_fall   <= 1'b0;
            ch_grant    <= '0;
            err_timeout <= 1'b0;
            err_ch      <= '0;
            rise_count  <= '0;
        end else begin
            core_rise <= 1'b0;
            core_fall <= 1'b0;
            if (err_clr) err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (!any_req && run) begin
                        state       <= RUN;
                        phase_cnt   <= '0;
                        half_active <= half_req;
                    end
                end
                RUN: begin
                    if (phase_end) begin
                        phase_cnt   <= '0;
                        core_clk    <= ~core_clk;
                        half_active <= half_req;
                        if (core_clk) begin
                            core_fall <= 1'b1;
                            if (!any_req && !run) state <= IDLE;
                        end else begin
                            core_rise  <= 1'b1;
                            rise_count <= rise_count + 32'd1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                GRANT: begin
                    // Completion outranks a watchdog expiry in the same cycle.
                    if (done_hit) begin
                        state    <= ARB;
                        ch_grant <= '0;
                    end else if (wdog == WD_LAST) begin
                        state       <= ARB;
                        ch_grant    <= '0;
                        err_timeout <= 1'b1;
                        err_ch      <= grant_idx;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ARB: begin
                    phase_cnt <= '0;
                    if (!any_req) state <= run ? RUN : IDLE;
                end
                default: state <= IDLE;
            endcase

            if (take_grant) begin
                state     <= GRANT;
                ch_grant  <= arb_grant;
                grant_idx <= win_idx;
                rr_ptr    <= next_ptr;
                wdog      <= '0;
            end
        end
    end

endmodule

// File: doc/core_clock_sequencer.md
# core_clock_sequencer

Parametrised successor to the single-ratio MIPS core clock divider. Generates the divided core clock from the system clock with a run-time half-period, and freezes it in the low phase to open transfer windows. Windows are granted to up to NUM_CH requesters by round-robin, each guarded by a watchdog. Sits between the system clock domain and the MIPS core plus its memory/IO transfer engines.

## Interface
- CNT_WIDTH, 16: width of half-period and phase counter.
- NUM_CH, 4: number of transfer requesters (1..16).
- DEFAULT_HALF, 2: half-period loaded at reset.
- MAX_GRANT, 1024: watchdog limit in clk cycles per grant (≥2).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  enable core clock toggling.
- half_period  in  CNT_WIDTH  requested half-period in clk cycles; 0 treated as 1.
- ch_req  in  NUM_CH  per-channel transfer-window request (level).
- ch_done  in  NUM_CH  per-channel completion; only the granted bit is honoured.
- err_clr  in  1  clears err_timeout.
- core_clk  out  1  divided core clock (registered).
- core_rise  out  1  one-cycle strobe coincident with the core_clk 0→1 update.
- core_fall  out  1  one-cycle strobe coincident with the core_clk 1→0 update.
- ch_grant  out  NUM_CH  one-hot grant, held until done or timeout.
- stalled  out  1  high in GRANT or ARB.
- err_timeout  out  1  sticky watchdog error.
- err_ch  out  $clog2(NUM_CH) (min 1)  channel of the last timeout.
- rise_count  out  32  core_clk rising edges since reset; wraps.

## Operation
- Reset values: state IDLE, core_clk 0, strobes 0, ch_grant 0, err_timeout 0, err_ch 0, rise_count 0, phase/watchdog counters 0, half_active = DEFAULT_HALF, RR pointer 0 (channel 0 highest).
- IDLE: core_clk held 0. If ch_req ≠ 0 → GRANT. Else if run → RUN, loading half_active from half_period.
- RUN: phase counter increments. At phase = half_active−1: counter←0, core_clk toggles, strobe fires, half_active reloads from half_period.
  - On a fall: ch_req ≠ 0 → GRANT; else run = 0 → IDLE; else stay in RUN.
  - run deasserted while core_clk is high: the high phase completes, then the fall applies.
- GRANT: ch_grant = RR winner. The watchdog counts.
  - ch_done[granted] → ARB.
  - Watchdog = MAX_GRANT−1 without done → ARB, err_timeout←1, err_ch←channel.
  - done and timeout in the same cycle: done wins, no error.
- ARB (one cycle, ch_grant = 0): ch_req ≠ 0 → GRANT (next winner); else → RUN if run, else IDLE. Phase counter is 0 on exit, so the resumed low phase is a full half_active.
- Requester contract: deassert ch_req no later than the cycle ch_done is asserted.
- RR: the pointer moves to one past the granted channel when the grant is issued. Search wraps modulo NUM_CH.
- err_clr and a new timeout in the same cycle: set wins.
- rise_count increments on core_rise and wraps 2^32−1 → 0.

## Timing
- Core clock period = 2 × half_active clk cycles. A half_period change takes effect from the next phase.
- ch_grant is asserted on the clk edge that performs the fall, so it goes high the same cycle core_clk goes low.
- Grant latency from IDLE: 1 cycle after ch_req is sampled.
- Grant drops 1 cycle after ch_done is sampled.
- Back-to-back grants are separated by exactly 1 ARB cycle.
- core_clk is never high while ch_grant ≠ 0.
- rst mid-operation: everything returns asynchronously to reset values. An active grant is dropped without an error.

## Structure
- Package core_clk_pkg holds:
  - state enum IDLE/RUN/GRANT/ARB;
  - the width function for err_ch;
  - the minimum-half constant 1.
- Sub-module rr_arbiter: parametrised by NUM_CH; inputs req and pointer; output one-hot grant. Purely combinational, reusable by the transfer engines.

## Test plan
- half_period=3, run=1, no req → core_clk period 6 clk; rise_count 5 after 5 rises; strobes single-cycle.
- ch_req[2] raised mid-high-phase → grant[2] on the fall edge, core_clk stays 0 until ch_done[2] + 1 ARB + 3 cycles, then rises.
- ch_req = 4'b1011 held, done after 2 cycles each → grant order 0, 1, 3, 0 with one ARB cycle between grants.
- MAX_GRANT=8, ch_req[1] without done → grant drops after 8 cycles; err_timeout=1, err_ch=1; err_clr clears it. Done on cycle 8 → no error.
- run=0 while core_clk high with half_period=4 → high phase completes, state IDLE, core_clk 0. Change half_period to 0 then run=1 → period 2 clk.
- rst asserted during GRANT → ch_grant, core_clk, and all counters 0 immediately; err_timeout stays 0.
